// File: rtl/led_bank_capture_pkg.sv
// led_bank_capture_pkg: shared constants, state encoding and bit-to-frame mapping for the LED bank link
package led_bank_capture_pkg;
  localparam int NUM_FRAMES = 18;
  localparam int GROUP_WIDTH = 9;
  typedef enum logic {WAIT0, WAIT1} state_t;
  // frame carried by lane i of group g; lane i travels on data[GROUP_WIDTH-1-i]
  function automatic int frame_idx(input int g, input int i);
    return g * GROUP_WIDTH + i;
  endfunction
endpackage

// File: rtl/led_bank_sync.sv
// led_bank_sync: multi-stage input synchronizer with a per-bit reset value
module led_bank_sync #(
  parameter int W = 12,
  parameter int STAGES = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_s [STAGES];
  // shift the raw inputs through the synchronizer chain
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 0; s < STAGES; s++) r_s[s] <= RST_VAL;
    end else begin
      r_s[0] <= d;
      for (int s = 1; s < STAGES; s++) r_s[s] <= r_s[s-1];
    end
  assign q = r_s[STAGES-1];
endmodule

// File: rtl/led_bank_capture.sv
// led_bank_capture: deserializes the LED bank serial link back into 18 parallel frames
module led_bank_capture
  import led_bank_capture_pkg::*;
#(
  parameter int FRAME_LENGTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               dclk,
  input  logic                               latch0,
  input  logic                               latch1,
  input  logic [GROUP_WIDTH-1:0]             data,
  output logic [NUM_FRAMES*FRAME_LENGTH-1:0] frames,
  output logic                               frame_valid,
  output logic                               busy,
  output logic                               error
);
  localparam int CW = $clog2(FRAME_LENGTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic                    w_dclk, w_latch0, w_latch1;
  logic [GROUP_WIDTH-1:0]  w_data;
  logic                    r_dclk_d;
  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [TW-1:0]           r_tmr;
  logic [FRAME_LENGTH-1:0] r_sr [NUM_FRAMES];
  logic [FRAME_LENGTH-1:0] w_sr_nx [NUM_FRAMES];
  logic w_rise, w_l0, w_l1, w_both, w_l0_err, w_l1_err, w_shift1, w_last, w_tout, w_err;
  // dclk idles high, so its synchronizer comes out of reset high to avoid a false rise
  led_bank_sync #(.W(GROUP_WIDTH + 3), .STAGES(SYNC_STAGES), .RST_VAL({1'b1, {(GROUP_WIDTH + 2){1'b0}}})) u_sync (
    .clk(clk),
    .reset(reset),
    .d({dclk, latch0, latch1, data}),
    .q({w_dclk, w_latch0, w_latch1, w_data})
  );
  assign w_rise   = w_dclk & ~r_dclk_d;
  assign w_l0     = w_rise & w_latch0 & ~w_latch1;
  assign w_l1     = w_rise & w_latch1 & ~w_latch0;
  assign w_both   = w_rise & w_latch0 & w_latch1;
  assign w_l0_err = w_l0 & (r_state == WAIT1);
  assign w_l1_err = w_l1 & (r_state == WAIT0);
  assign w_shift1 = w_l1 & (r_state == WAIT1);
  assign w_last   = w_shift1 && r_cnt == CW'(FRAME_LENGTH - 1);
  assign w_tout   = busy && !(w_l0 || w_shift1) && r_tmr == TW'(TIMEOUT - 1);
  assign w_err    = w_l0_err | w_l1_err | w_both | w_tout;
  // next shift register contents: the active group takes one MSB-first bit per frame
  always_comb begin
    w_sr_nx = r_sr;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < GROUP_WIDTH; i++)
        if (g == 0 ? w_l0 : w_shift1)
          w_sr_nx[frame_idx(g, i)] = {r_sr[frame_idx(g, i)][FRAME_LENGTH-2:0], w_data[GROUP_WIDTH-1-i]};
  end
  // protocol state, bit count, timeout timer and published frames
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_dclk_d    <= 1'b1;
      r_state     <= WAIT0;
      r_cnt       <= '0;
      r_tmr       <= '0;
      busy        <= 1'b0;
      error       <= 1'b0;
      frame_valid <= 1'b0;
      frames      <= '0;
      for (int k = 0; k < NUM_FRAMES; k++) r_sr[k] <= '0;
    end else begin
      r_dclk_d    <= w_dclk;
      error       <= w_err;
      frame_valid <= w_last;
      r_sr        <= w_sr_nx;
      if (w_l0) begin
        r_state <= WAIT1;
        busy    <= 1'b1;
        r_tmr   <= '0;
        r_cnt   <= w_l0_err ? '0 : r_cnt;
      end else if (w_shift1) begin
        r_state <= WAIT0;
        r_tmr   <= '0;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        busy    <= ~w_last;
        if (w_last)
          for (int k = 0; k < NUM_FRAMES; k++) frames[k*FRAME_LENGTH +: FRAME_LENGTH] <= w_sr_nx[k];
      end else if (w_err) begin
        r_state <= WAIT0;
        busy    <= 1'b0;
        r_cnt   <= '0;
        r_tmr   <= '0;
      end else begin
        r_tmr <= busy ? r_tmr + 1'b1 : '0;
      end
    end
endmodule

// File: tb/tb_led_bank_capture.sv
// tb_led_bank_capture: scoreboard bench driving the LED bank serial protocol into the capture block
module tb_led_bank_capture;
  localparam int FL = 32;
  localparam int NF = 18;
  localparam int TO = 64;
  logic clk = 0, reset = 0, dclk = 1, latch0 = 0, latch1 = 0;
  logic [8:0] data = '0;
  logic [NF*FL-1:0] frames;
  logic frame_valid, busy, error;
  logic [NF*FL-1:0] exp_q [$];
  logic [NF*FL-1:0] last_frames = '0;
  int n_chk = 0, n_fail = 0, n_valid = 0, n_err = 0;

  led_bank_capture #(.FRAME_LENGTH(FL), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .dclk(dclk), .latch0(latch0), .latch1(latch1), .data(data),
    .frames(frames), .frame_valid(frame_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset) begin
      if (error) n_err++;
      if (frame_valid) begin
        n_valid++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: frame_valid with empty scoreboard, frames=%h", frames);
        end else begin
          logic [NF*FL-1:0] e;
          e = exp_q.pop_front();
          if (frames !== e) begin
            n_fail++;
            $display("FAIL frames: got %h expected %h", frames, e);
          end
        end
        n_chk++;
        if (error) begin
          n_fail++;
          $display("FAIL valid_and_error: error=%b required 0 while frame_valid", error);
        end
      end
    end

  task automatic rise(input logic l0, input logic l1, input logic [8:0] d);
    @(negedge clk) dclk = 0;
    repeat (2) @(negedge clk);
    latch0 = l0; latch1 = l1; data = d;
    @(negedge clk) dclk = 1;
    @(negedge clk) begin latch0 = 0; latch1 = 0; end
    @(negedge clk);
  endtask

  task automatic send(input logic [NF*FL-1:0] f, input int npairs);
    logic [8:0] d;
    for (int p = 0; p < npairs; p++) begin
      for (int g = 0; g < 2; g++) begin
        for (int i = 0; i < 9; i++) d[8-i] = f[(g*9+i)*FL + (FL-1-p)];
        rise(g == 0, g == 1, d);
      end
    end
  endtask

  function automatic logic [NF*FL-1:0] pat(input logic [FL-1:0] base, input logic add_k);
    logic [NF*FL-1:0] f;
    for (int k = 0; k < NF; k++) f[k*FL +: FL] = add_k ? (base | FL'(k)) : base;
    return f;
  endfunction

  task automatic full(input logic [NF*FL-1:0] f, input string name);
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    exp_q.push_back(f);
    send(f, FL);
    repeat (10) @(negedge clk);
    last_frames = f;
    n_chk++;
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL %s_valid_count: got %0d required 1", name, n_valid - v0); end
    n_chk++;
    if (n_err !== e0) begin n_fail++; $display("FAIL %s_errors: got %0d required 0", name, n_err - e0); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b required 0", name, busy); end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (frames !== '0 || busy !== 0 || error !== 0 || frame_valid !== 0) begin
      n_fail++;
      $display("FAIL reset_state: frames=%h busy=%b error=%b valid=%b required all 0", frames, busy, error, frame_valid);
    end
    reset = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_loopback();
    full(pat(32'hA5000000, 1'b1), "loopback");
  endtask

  task automatic test_back_to_back();
    full(pat(32'hFFFFFFFF, 1'b0), "ones");
    full(pat(32'h00000000, 1'b0), "zeros");
    full(pat(32'h3C000000, 1'b1), "mixed");
  endtask

  task automatic test_timeout();
    int e0;
    e0 = n_err;
    send(pat(32'h12345678, 1'b1), 10);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_mid: got %b required 1", busy); end
    repeat (TO - 10) @(negedge clk);
    n_chk++;
    if (n_err !== e0) begin n_fail++; $display("FAIL timeout_early: got %0d errors required 0 before TIMEOUT", n_err - e0); end
    repeat (15) @(negedge clk);
    n_chk++;
    if (n_err - e0 !== 1) begin n_fail++; $display("FAIL timeout_error: got %0d errors required 1", n_err - e0); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b required 0", busy); end
    n_chk++;
    if (frames !== last_frames) begin n_fail++; $display("FAIL timeout_frames: got %h required %h", frames, last_frames); end
    full(pat(32'h5A5A0000, 1'b1), "after_timeout");
  endtask

  task automatic test_bad_group();
    int e0;
    e0 = n_err;
    rise(1'b0, 1'b1, 9'h1AB);
    repeat (4) @(negedge clk);
    n_chk++;
    if (n_err - e0 !== 1) begin n_fail++; $display("FAIL bad_group_error: got %0d errors required 1", n_err - e0); end
    n_chk++;
    if (frames !== last_frames) begin n_fail++; $display("FAIL bad_group_frames: got %h required %h", frames, last_frames); end
    full(pat(32'hC0DE0000, 1'b1), "after_bad_group");
  endtask

  task automatic test_reset_mid();
    send(pat(32'h0F0F0000, 1'b1), 16);
    @(negedge clk);
    #2 reset = 1;
    #1;
    n_chk++;
    if (frames !== '0) begin n_fail++; $display("FAIL async_reset_frames: got %h required 0", frames); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b required 0", busy); end
    repeat (3) @(negedge clk);
    reset = 0;
    last_frames = '0;
    repeat (3) @(negedge clk);
    full(pat(32'h87650000, 1'b1), "after_reset");
  endtask

  task automatic test_both_latches();
    int e0;
    send(pat(32'h11110000, 1'b1), 5);
    e0 = n_err;
    rise(1'b1, 1'b1, 9'h1FF);
    repeat (4) @(negedge clk);
    n_chk++;
    if (n_err - e0 !== 1) begin n_fail++; $display("FAIL both_latches_error: got %0d errors required 1", n_err - e0); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL both_latches_busy: got %b required 0", busy); end
    rise(1'b0, 1'b1, 9'h000);
    repeat (4) @(negedge clk);
    n_chk++;
    if (n_err - e0 !== 2) begin n_fail++; $display("FAIL both_latches_state: got %0d errors required 2", n_err - e0); end
    n_chk++;
    if (frames !== last_frames) begin n_fail++; $display("FAIL both_latches_frames: got %h required %h", frames, last_frames); end
    full(pat(32'hBEEF0000, 1'b1), "after_both");
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_timeout();
    test_bad_group();
    test_reset_mid();
    test_both_latches();
    n_chk++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
